// File: rtl/flopr_async.sv
// Resettable D flop of WIDTH bits: one-cycle pipeline delay with an asynchronous,
// active-low reset that forces q to RESET_VAL immediately.
module flopr_async #(
  parameter int unsigned         WIDTH     = 8,
  parameter logic [WIDTH-1:0]    RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Reset is in the sensitivity list so assertion takes effect without a clock edge
  // and holds off any coincident capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: tb/tb_flopr_async.sv
// Self-checking bench for flopr_async: three instances (32-bit, 3-bit, 8-bit with a
// non-zero reset value) driven by directed scenarios and a randomized run.
module tb_flopr_async;

  logic        clk;
  logic        rst32, rst3, rst8;
  logic [31:0] d32, q32;
  logic [2:0]  d3, q3;
  logic [7:0]  d8, q8;

  int checks;
  int failures;

  flopr_async #(.WIDTH(32)) u_w32 (.clk(clk), .reset(rst32), .d(d32), .q(q32));
  flopr_async #(.WIDTH(3))  u_w3  (.clk(clk), .reset(rst3),  .d(d3),  .q(q3));
  flopr_async #(.WIDTH(8), .RESET_VAL(8'hA5)) u_w8 (.clk(clk), .reset(rst8), .d(d8), .q(q8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic test_reset;
    rst32 = 1'b0;
    d32   = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (q32 !== 32'h0000_0000) begin
        failures++;
        $display("FAIL reset_hold cycle %0d: q=%h required %h", i, q32, 32'h0);
      end
      d32 = d32 ^ 32'hFFFF_0000;
    end
  endtask

  task automatic test_capture;
    @(negedge clk);
    rst32 = 1'b1;
    d32   = 32'h1234_5678;
    @(posedge clk); #1;
    checks++;
    if (q32 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL capture_n: q=%h required %h", q32, 32'h1234_5678);
    end
    d32 = 32'h5555_5555;
    #2;
    checks++;
    if (q32 !== 32'h1234_5678) begin
      failures++;
      $display("FAIL hold_mid_cycle: q=%h required %h", q32, 32'h1234_5678);
    end
    @(negedge clk);
    d32 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    checks++;
    if (q32 !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL capture_n1: q=%h required %h", q32, 32'hCAFE_F00D);
    end
  endtask

  task automatic test_async_assert;
    rst3 = 1'b0;
    d3   = 3'b111;
    @(negedge clk);
    rst3 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q3 !== 3'b111) begin
      failures++;
      $display("FAIL preload_111: q=%b required %b", q3, 3'b111);
    end
    #1;
    rst3 = 1'b0;
    #1;
    checks++;
    if (q3 !== 3'b000) begin
      failures++;
      $display("FAIL async_assert: q=%b required %b", q3, 3'b000);
    end
  endtask

  task automatic test_release;
    d3 = 3'b101;
    @(negedge clk);
    rst3 = 1'b1;
    #2;
    checks++;
    if (q3 !== 3'b000) begin
      failures++;
      $display("FAIL release_no_change: q=%b required %b", q3, 3'b000);
    end
    @(posedge clk); #1;
    checks++;
    if (q3 !== 3'b101) begin
      failures++;
      $display("FAIL first_capture: q=%b required %b", q3, 3'b101);
    end
  endtask

  task automatic test_coincident;
    d3 = 3'b011;
    @(posedge clk);
    rst3 = 1'b0;
    #1;
    checks++;
    if (q3 !== 3'b000) begin
      failures++;
      $display("FAIL coincident_edge: q=%b required %b", q3, 3'b000);
    end
    @(posedge clk); #1;
    checks++;
    if (q3 !== 3'b000) begin
      failures++;
      $display("FAIL reset_ignores_clk: q=%b required %b", q3, 3'b000);
    end
  endtask

  task automatic test_reset_val;
    rst8 = 1'b0;
    d8   = 8'h3C;
    #1;
    checks++;
    if (q8 !== 8'hA5) begin
      failures++;
      $display("FAIL reset_val: q=%h required %h", q8, 8'hA5);
    end
    @(negedge clk);
    rst8 = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'h3C) begin
      failures++;
      $display("FAIL reset_val_capture: q=%h required %h", q8, 8'h3C);
    end
  endtask

  // Model: q after an edge is whatever d was driven to before that edge.
  task automatic test_random;
    logic [31:0] sent[$];
    logic [31:0] v;
    logic [31:0] exp;
    int          bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      v = $urandom;
      if ($urandom_range(0, 9) == 0) v[$urandom_range(0, 31)] = 1'bx;
      d32 = v;
      sent.push_back(v);
      @(posedge clk); #1;
      exp = sent.pop_front();
      checks++;
      if (q32 !== exp) begin
        failures++;
        if (bad < 10) $display("FAIL random cycle %0d: q=%h required %h", i, q32, exp);
        bad++;
      end
      // Change d mid-cycle; q must not follow until the next edge.
      d32 = ~v;
      #2;
      checks++;
      if (q32 !== exp) begin
        failures++;
        if (bad < 10) $display("FAIL random_hold cycle %0d: q=%h required %h", i, q32, exp);
        bad++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst32 = 1'b0;
    rst3  = 1'b0;
    rst8  = 1'b0;
    d32   = '0;
    d3    = '0;
    d8    = '0;
    test_reset();
    test_capture();
    test_async_assert();
    test_release();
    test_coincident();
    test_reset_val();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
